// File: rtl/jtframe_ddrarb_pkg.sv
// Shared types and constants for the MiSTer DDR3 burst arbiter.
package jtframe_ddrarb_pkg;

  localparam int BLW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RDWAIT  = 2'd2,
    WRBURST = 2'd3
  } state_t;

  typedef enum logic {
    OWN_LDR = 1'b0,
    OWN_ROT = 1'b1
  } owner_t;

endpackage

// File: rtl/jtframe_ddrarb_beatcnt.sv
// Beat counter for one DDR burst: latches the burst length (0 counts as 1)
// and flags when the next counted beat is the final one.
module jtframe_ddrarb_beatcnt
  import jtframe_ddrarb_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           first,
  input  logic           inc,
  input  logic [BLW-1:0] len_in,
  output logic [BLW-1:0] len,
  output logic           last
);

  logic [BLW-1:0] cnt;
  logic [BLW-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;
  assign last    = (cnt_inc == len);

  // a write is loaded together with its first accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      len <= '0;
    end else if (load) begin
      len <= (len_in == '0) ? BLW'(1) : len_in;
      cnt <= first ? BLW'(1) : '0;
    end else if (inc) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/jtframe_mr_ddrarb.sv
// Burst-aware arbiter sharing the MiSTer DDR3 port between ROM loader and
// rotation buffer. Define JTFRAME_MR_DDRARB_RR_EN for round-robin ties.
module jtframe_mr_ddrarb
  import jtframe_ddrarb_pkg::*;
#(
  parameter int AW  = 29,
  parameter int DW  = 64,
  parameter int BEW = DW/8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ldr_addr,
  input  logic [7:0]    ldr_burstcnt,
  input  logic          ldr_rd,
  output logic          ldr_busy,
  output logic          ldr_dout_ready,
  input  logic [AW-1:0] rot_addr,
  input  logic [7:0]    rot_burstcnt,
  input  logic          rot_rd,
  input  logic          rot_we,
  input  logic [BEW-1:0] rot_be,
  input  logic [DW-1:0] rot_din,
  output logic          rot_busy,
  output logic          rot_dout_ready,
  input  logic          ddr_busy,
  input  logic          ddr_dout_ready,
  output logic [AW-1:0] ddr_addr,
  output logic [7:0]    ddr_burstcnt,
  output logic          ddr_rd,
  output logic          ddr_we,
  output logic [BEW-1:0] ddr_be,
  output logic [DW-1:0] ddr_din
);

  state_t         st, st_nxt;
  owner_t         own, win;
  logic [AW-1:0]  addr_p0;
  logic           pending;
  logic [AW-1:0]  sel_addr;
  logic [7:0]     sel_cnt;
  logic           sel_rd, sel_we;
  logic           rd_acc, wr_acc;
  logic           cnt_load, cnt_first, cnt_inc, cnt_last;
  logic [BLW-1:0] cnt_len;

  assign pending = ldr_rd | rot_rd | rot_we;

`ifdef JTFRAME_MR_DDRARB_RR_EN
  owner_t prio;

  always_comb begin
    if (ldr_rd && (rot_rd || rot_we)) win = prio;
    else if (ldr_rd)                  win = OWN_LDR;
    else                              win = OWN_ROT;
  end

  // the side that loses a grant is favoured on the next tie
  always_ff @(posedge clk) begin
    if (rst) prio <= OWN_LDR;
    else if (st == IDLE && pending) prio <= (win == OWN_LDR) ? OWN_ROT : OWN_LDR;
  end
`else
  assign win = ldr_rd ? OWN_LDR : OWN_ROT;
`endif

  assign sel_addr = (own == OWN_LDR) ? ldr_addr     : rot_addr;
  assign sel_cnt  = (own == OWN_LDR) ? ldr_burstcnt : rot_burstcnt;
  assign sel_rd   = (own == OWN_LDR) ? ldr_rd       : rot_rd;
  assign sel_we   = (own == OWN_ROT) & rot_we;
  assign rd_acc   = sel_rd & ~ddr_busy;
  assign wr_acc   = sel_we & ~sel_rd & ~ddr_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      own <= OWN_LDR;
    end else begin
      st <= st_nxt;
      if (st == IDLE && pending) own <= win;
    end
  end

  always_ff @(posedge clk) begin
    if (cnt_load) addr_p0 <= sel_addr;
  end

  always_comb begin
    st_nxt       = st;
    ldr_busy     = 1'b1;
    rot_busy     = 1'b1;
    ddr_addr     = '0;
    ddr_burstcnt = '0;
    ddr_rd       = 1'b0;
    ddr_we       = 1'b0;
    ddr_be       = '0;
    ddr_din      = '0;
    cnt_load     = 1'b0;
    cnt_first    = 1'b0;
    cnt_inc      = 1'b0;
    case (st)
      IDLE: begin
        if (pending) st_nxt = GRANT;
      end
      GRANT: begin
        ddr_addr     = sel_addr;
        ddr_burstcnt = sel_cnt;
        ddr_rd       = sel_rd;
        ddr_we       = sel_we & ~sel_rd;
        ddr_be       = (own == OWN_LDR) ? '1 : rot_be;
        ddr_din      = (own == OWN_LDR) ? '0 : rot_din;
        if (own == OWN_LDR) ldr_busy = ddr_busy;
        else                rot_busy = ddr_busy;
        if (rd_acc) begin
          cnt_load = 1'b1;
          st_nxt   = RDWAIT;
        end else if (wr_acc) begin
          cnt_load  = 1'b1;
          cnt_first = 1'b1;
          st_nxt    = (sel_cnt <= 8'd1) ? IDLE : WRBURST;
        end else if (!sel_rd && !sel_we) begin
          st_nxt = IDLE;
        end
      end
      RDWAIT: begin
        ddr_addr     = addr_p0;
        ddr_burstcnt = cnt_len;
        cnt_inc      = ddr_dout_ready;
        if (ddr_dout_ready && cnt_last) st_nxt = IDLE;
      end
      WRBURST: begin
        ddr_addr     = addr_p0;
        ddr_burstcnt = cnt_len;
        ddr_we       = rot_we;
        ddr_be       = rot_be;
        ddr_din      = rot_din;
        rot_busy     = ddr_busy;
        cnt_inc      = rot_we & ~ddr_busy;
        if (cnt_inc && cnt_last) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
    // handshakes are held off for the whole reset cycle
    if (rst) begin
      ldr_busy = 1'b1;
      rot_busy = 1'b1;
      ddr_rd   = 1'b0;
      ddr_we   = 1'b0;
    end
  end

  assign ldr_dout_ready = ~rst & (st == RDWAIT) & (own == OWN_LDR) & ddr_dout_ready;
  assign rot_dout_ready = ~rst & (st == RDWAIT) & (own == OWN_ROT) & ddr_dout_ready;

  jtframe_ddrarb_beatcnt u_beatcnt (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .first  (cnt_first),
    .inc    (cnt_inc),
    .len_in (sel_cnt),
    .len    (cnt_len),
    .last   (cnt_last)
  );

endmodule

// File: tb/tb_jtframe_mr_ddrarb.sv
// Bench for jtframe_mr_ddrarb: vector table, corner sequences and a
// randomized two-requester run against a transaction-level DDR model.
module tb_jtframe_mr_ddrarb;

  localparam int AW  = 29;
  localparam int DW  = 64;
  localparam int BEW = DW/8;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  ldr_addr, rot_addr, ddr_addr;
  logic [7:0]     ldr_burstcnt, rot_burstcnt, ddr_burstcnt;
  logic           ldr_rd, ldr_busy, ldr_dout_ready;
  logic           rot_rd, rot_we, rot_busy, rot_dout_ready;
  logic [BEW-1:0] rot_be, ddr_be;
  logic [DW-1:0]  rot_din, ddr_din;
  logic           ddr_busy, ddr_dout_ready, ddr_rd, ddr_we;

  int vectors = 0;
  int miscompares = 0;

  jtframe_mr_ddrarb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .ldr_addr(ldr_addr), .ldr_burstcnt(ldr_burstcnt), .ldr_rd(ldr_rd),
    .ldr_busy(ldr_busy), .ldr_dout_ready(ldr_dout_ready),
    .rot_addr(rot_addr), .rot_burstcnt(rot_burstcnt), .rot_rd(rot_rd),
    .rot_we(rot_we), .rot_be(rot_be), .rot_din(rot_din),
    .rot_busy(rot_busy), .rot_dout_ready(rot_dout_ready),
    .ddr_busy(ddr_busy), .ddr_dout_ready(ddr_dout_ready),
    .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt), .ddr_rd(ddr_rd),
    .ddr_we(ddr_we), .ddr_be(ddr_be), .ddr_din(ddr_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ldr_addr = '0; ldr_burstcnt = '0; ldr_rd = 1'b0;
    rot_addr = '0; rot_burstcnt = '0; rot_rd = 1'b0; rot_we = 1'b0;
    rot_be = '0; rot_din = '0; ddr_busy = 1'b0; ddr_dout_ready = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       l_rd, r_rd, r_we, d_busy;
    logic [3:0] e_ctl;  // {ldr_busy, rot_busy, ddr_rd, ddr_we}
    logic       e_ldr;
    logic [7:0] e_be;
  } vec_t;

  vec_t vt[6];

  // random-phase model state
  logic          l_act;
  logic [AW-1:0] l_addr, r_addr;
  logic [7:0]    l_cnt, r_cnt, r_be;
  logic [DW-1:0] r_din;
  int            l_left, r_left, l_gap, r_gap, r_mode, r_bl, guard;
  bit            rq_own[$];
  int            rq_n[$];

  initial begin
    logic la, ra, wa, dra, dwa, own, cur_own;
    int beats, dbeats, k, g, pend, cnt_l, cnt_r, exp_own;
    logic [6:0] pat;

    // reset: dout gated, then quiet idle
    clear_inputs();
    rst = 1'b1;
    ddr_dout_ready = 1'b1;
    #1 chk("rst_dout", 96'({ldr_dout_ready, rot_dout_ready}), 96'(0));
    nxt();
    #1 chk("rst_dout2", 96'({ldr_dout_ready, rot_dout_ready}), 96'(0));
    nxt();
    rst = 1'b0;
    ddr_dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 chk("idle_quiet", 96'({ldr_busy, rot_busy, ddr_rd, ddr_we}), 96'(4'b1100));
      nxt();
    end

    // grant forwarding table
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 8'hFF};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b1110, 1'b1, 8'hFF};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 8'h3C};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, 1'b0, 8'h3C};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 8'hFF};
    vt[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b1110, 1'b1, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      reset_dut();
      ldr_addr = 29'h100; ldr_burstcnt = 8'd4; rot_addr = 29'h2AB; rot_burstcnt = 8'd3;
      rot_be = 8'h3C; rot_din = 64'h1234;
      ldr_rd = vt[i].l_rd; rot_rd = vt[i].r_rd; rot_we = vt[i].r_we; ddr_busy = vt[i].d_busy;
      #1 chk("vec_idle", 96'({ldr_busy, rot_busy, ddr_rd, ddr_we}), 96'(4'b1100));
      nxt();
      #1 chk("vec_ctl", 96'({ldr_busy, rot_busy, ddr_rd, ddr_we}), 96'(vt[i].e_ctl));
      chk("vec_cmd", 96'({ddr_addr, ddr_burstcnt, ddr_be}),
          vt[i].e_ldr ? 96'({29'h100, 8'd4, vt[i].e_be}) : 96'({29'h2AB, 8'd3, vt[i].e_be}));
    end

    // loader read of 4 beats with gapped valid pulses
    reset_dut();
    ldr_rd = 1'b1; ldr_addr = 29'h100; ldr_burstcnt = 8'd4; ddr_busy = 1'b1;
    #1 chk("t2_idle", 96'({ldr_busy, ddr_rd}), 96'(2'b10));
    nxt();
    #1 chk("t2_fwd", 96'({ddr_rd, ddr_addr, ddr_burstcnt, ldr_busy}), 96'({1'b1, 29'h100, 8'd4, 1'b1}));
    nxt();
    #1 chk("t2_wait", 96'(ldr_busy), 96'(1));
    nxt();
    ddr_busy = 1'b0;
    #1 chk("t2_acc", 96'(ldr_busy), 96'(0));
    nxt();
    ldr_rd = 1'b0;
    pat = 7'b1001101;
    cnt_l = 0; cnt_r = 0;
    for (int i = 0; i < 7; i++) begin
      ddr_dout_ready = pat[i];
      #1 chk("t2_dv", 96'({ldr_dout_ready, rot_dout_ready, ddr_rd}), 96'({pat[i], 2'b00}));
      cnt_l += int'(ldr_dout_ready); cnt_r += int'(rot_dout_ready);
      nxt();
    end
    chk("t2_cnt", 96'({cnt_l, cnt_r}), 96'({32'd4, 32'd0}));
    ddr_dout_ready = 1'b1; ldr_rd = 1'b1; ddr_busy = 1'b1;
    #1 chk("t2_stray", 96'({ldr_dout_ready, ddr_rd}), 96'(0));
    nxt();
    ddr_dout_ready = 1'b0;
    #1 chk("t2_regrant", 96'(ddr_rd), 96'(1));
    nxt();
    ldr_rd = 1'b0;

    // rotation write of 8 beats, loader waiting behind it
    reset_dut();
    rot_we = 1'b1; rot_addr = 29'h2000; rot_burstcnt = 8'd8; rot_be = 8'hFF; rot_din = 64'hA0;
    beats = 0; dbeats = 0; k = 0;
    while (beats < 8 && k < 60) begin
      ddr_busy = k[0];
      if (beats >= 3) begin ldr_rd = 1'b1; ldr_addr = 29'h300; ldr_burstcnt = 8'd1; end
      #1;
      chk("t3_acc", 96'(ddr_we & ~ddr_busy), 96'(rot_we & ~rot_busy));
      if (ddr_we && !ddr_busy) begin
        dbeats++;
        chk("t3_beat", 96'({ddr_din, ddr_burstcnt, ddr_addr}), 96'({rot_din, 8'd8, 29'h2000}));
      end
      if (ldr_rd) chk("t3_ldr_hold", 96'(ldr_busy), 96'(1));
      if (rot_we && !rot_busy) beats++;
      nxt();
      k++;
      rot_din = 64'hA0 + 64'(beats);
    end
    rot_we = 1'b0;
    ddr_busy = 1'b1;
    #1 chk("t3_gap", 96'({ldr_busy, ddr_we, ddr_rd}), 96'(3'b100));
    nxt();
    ddr_busy = 1'b0;
    #1 chk("t3_ldr_grant", 96'({ddr_rd, ldr_busy, ddr_addr}), 96'({2'b10, 29'h300}));
    nxt();
    ldr_rd = 1'b0; ddr_dout_ready = 1'b1;
    #1 chk("t3_ldr_data", 96'({ldr_dout_ready, rot_dout_ready}), 96'(2'b10));
    nxt();
    ddr_dout_ready = 1'b0;
    chk("t3_beats", 96'(dbeats), 96'(8));

    // both requesters read continuously, burst of 2
    reset_dut();
    ldr_rd = 1'b1; rot_rd = 1'b1; ldr_addr = 29'h10; rot_addr = 29'h20;
    ldr_burstcnt = 8'd2; rot_burstcnt = 8'd2;
    g = 0; pend = 0; k = 0; cur_own = 1'b0;
    while (g < 6 && k < 100) begin
      ddr_dout_ready = (pend > 0);
      #1;
      if (ddr_dout_ready) begin
        chk("t4_dv", 96'({ldr_dout_ready, rot_dout_ready}), cur_own ? 96'(2'b01) : 96'(2'b10));
        pend--;
      end
      if (ddr_rd && !ddr_busy) begin
        own = ldr_busy;
`ifdef JTFRAME_MR_DDRARB_RR_EN
        exp_own = g % 2;
`else
        exp_own = 0;
`endif
        chk("t4_owner", 96'(own), 96'(exp_own));
        cur_own = own;
        pend = 2;
        g++;
      end
      nxt();
      k++;
    end
    chk("t4_grants", 96'(g), 96'(6));

    // reset in the middle of a 4-beat read
    reset_dut();
    ldr_rd = 1'b1; ldr_addr = 29'h40; ldr_burstcnt = 8'd4;
    nxt();
    nxt();
    ldr_rd = 1'b0; ddr_dout_ready = 1'b1;
    #1 chk("t5_beat1", 96'(ldr_dout_ready), 96'(1));
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0; rot_rd = 1'b1; rot_addr = 29'h55; rot_burstcnt = 8'd2; ddr_busy = 1'b1;
    #1 chk("t5_beat3", 96'({ldr_dout_ready, rot_dout_ready, ddr_rd}), 96'(0));
    nxt();
    #1 chk("t5_beat4", 96'({ldr_dout_ready, rot_dout_ready}), 96'(0));
    chk("t5_regrant", 96'({ddr_rd, rot_busy, ddr_addr}), 96'({2'b11, 29'h55}));
    nxt();
    rot_rd = 1'b0; ddr_dout_ready = 1'b0;

    // write with burstcnt 0 is one beat
    reset_dut();
    rot_we = 1'b1; rot_addr = 29'h77; rot_burstcnt = 8'd0; rot_din = 64'h5A; rot_be = 8'h0F;
    nxt();
    #1 chk("t6_acc", 96'({ddr_we, rot_busy, ddr_din}), 96'({2'b10, 64'h5A}));
    nxt();
    #1 chk("t6_idle", 96'({ddr_we, rot_busy}), 96'(2'b01));
    nxt();
    ddr_busy = 1'b1;
    #1 chk("t6_regrant", 96'(ddr_we), 96'(1));
    nxt();
    rot_we = 1'b0;

    // randomized traffic against the transaction model
    reset_dut();
    l_act = 1'b0; l_left = 30; r_left = 30; l_gap = 0; r_gap = 0; r_mode = 0; r_bl = 0;
    l_addr = '0; l_cnt = '0; r_addr = '0; r_cnt = '0; r_be = '0; r_din = '0; guard = 0;
    while ((l_left > 0 || r_left > 0 || l_act || r_mode != 0 || rq_n.size() > 0) && guard < 20000) begin
      ddr_busy = ($urandom_range(0, 3) == 0);
      ddr_dout_ready = (rq_n.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      ldr_rd = l_act; ldr_addr = l_addr; ldr_burstcnt = l_cnt;
      rot_rd = (r_mode == 1); rot_we = (r_mode == 2);
      rot_addr = r_addr; rot_burstcnt = r_cnt; rot_din = r_din; rot_be = r_be;
      #1;
      la  = ldr_rd & ~ldr_busy;
      ra  = rot_rd & ~rot_busy;
      wa  = rot_we & ~rot_busy;
      dra = ddr_rd & ~ddr_busy;
      dwa = ddr_we & ~ddr_busy;
      if (ddr_dout_ready) begin
        if (rq_n.size() > 0) begin
          chk("r_dv", 96'({ldr_dout_ready, rot_dout_ready}), rq_own[0] ? 96'(2'b01) : 96'(2'b10));
          rq_n[0]--;
          if (rq_n[0] == 0) begin void'(rq_own.pop_front()); void'(rq_n.pop_front()); end
        end else begin
          chk("r_stray", 96'({ldr_dout_ready, rot_dout_ready}), 96'(0));
        end
      end
      chk("r_rd_acc", 96'(dra), 96'(la | ra));
      chk("r_wr_acc", 96'(dwa), 96'(wa));
      if (dra) begin
        chk("r_rd_cmd", 96'({ddr_addr, ddr_burstcnt}),
            la ? 96'({l_addr, l_cnt}) : 96'({r_addr, r_cnt}));
        rq_own.push_back(!la);
        rq_n.push_back(la ? ((l_cnt == 0) ? 1 : int'(l_cnt)) : ((r_cnt == 0) ? 1 : int'(r_cnt)));
      end
      if (dwa) chk("r_wr_cmd", 96'({ddr_addr, ddr_burstcnt, ddr_be, ddr_din}),
                   96'({r_addr, r_cnt, r_be, r_din}));
      if (la) begin l_act = 1'b0; l_left--; l_gap = $urandom_range(0, 20); end
      if (ra) begin r_mode = 0; r_left--; r_gap = $urandom_range(0, 5); end
      if (wa) begin
        r_bl--;
        if (r_bl == 0) begin r_mode = 0; r_left--; r_gap = $urandom_range(0, 5); end
        else begin r_din = {$urandom, $urandom}; r_be = 8'($urandom); end
      end
      nxt();
      guard++;
      if (!l_act && l_left > 0) begin
        if (l_gap > 0) l_gap--;
        else begin l_act = 1'b1; l_addr = AW'($urandom); l_cnt = 8'($urandom_range(0, 5)); end
      end
      if (r_mode == 0 && r_left > 0) begin
        if (r_gap > 0) r_gap--;
        else begin
          r_mode = $urandom_range(1, 2);
          r_addr = AW'($urandom); r_cnt = 8'($urandom_range(0, 5));
          r_bl = (r_cnt == 0) ? 1 : int'(r_cnt);
          r_din = {$urandom, $urandom}; r_be = 8'($urandom);
        end
      end
    end
    chk("r_complete", 96'(guard < 20000), 96'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
